buffer_fifo: RTL and testbench
==============================

// Module: buffer_fifo
// PURPOSE
//   Parametrised, clocked successor to the 16-bit pass-through buffer: a synchronous
//   FIFO buffer of DEPTH words of WIDTH bits with valid/ready handshakes on both sides.
//   Decouples a producer datapath from a consumer stage; data order is preserved.
//   Sits between arithmetic units and downstream result consumers in the datapath.
// PARAMETERS
//   WIDTH   16  data word width in bits (>=1)
//   DEPTH   4   storage depth in words; power of two, >=2
//   ADDR_W  $clog2(DEPTH)  derived (localparam): pointer width; level width is ADDR_W+1
// PORTS
//   clk        in   1          rising-edge clock; the only clock
//   rst_n      in   1          asynchronous, active-low reset
//   in_valid   in   1          producer presents in_data this cycle
//   in_ready   out  1          buffer accepts a word this cycle (= !full)
//   in_data    in   WIDTH      write data
//   out_valid  out  1          out_data holds the oldest word
//   out_ready  in   1          consumer takes out_data this cycle
//   out_data   out  WIDTH      oldest stored word; 0 when out_valid=0
//   level      out  ADDR_W+1   words currently stored, 0..DEPTH
//   full       out  1          level==DEPTH
//   empty      out  1          level==0
// BEHAVIOUR
// - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, level=0, empty=1, full=0, out_valid=0,
//   out_data=0, in_ready=0 while rst_n low. Storage array is not reset.
// - Reset released: in_ready=1 from the first cycle after rst_n rises.
// - Reset mid-operation: all stored words are discarded. A push in the reset-release
//   cycle is ignored because in_ready is low.
// - Push when in_valid&&in_ready at posedge: mem[wr_ptr]<=in_data, wr_ptr++ (mod DEPTH).
// - Pop when out_valid&&out_ready at posedge: rd_ptr++ (mod DEPTH).
// - Level update: push only -> level+1; pop only -> level-1; push and pop -> unchanged.
// - in_ready = !full. It never depends combinationally on out_ready, so there is no push
//   while full, even if a pop occurs in the same cycle.
// - out_valid = !empty. out_data = mem[rd_ptr], read combinationally from the array.
// - Latency: a word pushed at edge N is visible on out_data after edge N (cycle N+1).
//   Throughput is 1 word/cycle in steady state.
// - Pop while empty is ignored (out_valid=0). Push while full is ignored (in_ready=0).
//   Pointers and level never under- or overflow.
// - Pointers wrap from DEPTH-1 to 0. full and empty are decoded from level, never from
//   pointer equality.
// - Producer rule: in_valid/in_data are held until accepted. The buffer does not require
//   this, but the bench checks it.
// CONFIGURATION
//   BUFFER_FIFO_BYPASS_EN
//   - Defined: when empty and in_valid=1, out_valid=1 and out_data=in_data in the same
//     cycle (zero latency).
//     - If out_ready=1 in that cycle, the word is consumed: it is not written, and the
//       pointers and level are unchanged.
//     - If out_ready=0, the word is written normally.
//     - in_ready stays !full.
//   - Undefined: no bypass. Minimum latency is 1 cycle as above.
// TESTING
// 1 Reset: rst_n=0 -> level=0, empty=1, full=0, out_valid=0, out_data=0, in_ready=0;
//   release -> in_ready=1 next cycle.
// 2 Fill/drain with DEPTH=4 and out_ready=0: push 0xA001..0xA004 -> full=1, level=4,
//   in_ready=0. A 5th push of 0xA005 is dropped. Then out_ready=1 -> outputs
//   A001,A002,A003,A004 in order, then empty=1.
// 3 Streaming with in_valid=out_ready=1 for 10 cycles on data 0..9: level holds at 1,
//   output is 0..9 in order, exactly one cycle behind the input. Pointers wrap twice.
// 4 Simultaneous push/pop at level=2 (0x0011 then 0x0022 stored), push 0x0033:
//   level stays 2, out_data=0x0022 next.
// 5 Reset mid-stream at level=3: assert rst_n=0 -> level=0, out_valid=0 immediately.
//   After release, push 0xBEEF -> out_data=0xBEEF, level=1.
// 6 With BUFFER_FIFO_BYPASS_EN: empty, in_valid=1, in_data=0x1234, out_ready=1 ->
//   same cycle out_valid=1 and out_data=0x1234; level stays 0. Without the macro:
//   out_valid=0 that cycle, and 0x1234 appears the next cycle.

Source files
------------

// File: rtl/buffer_fifo.sv
// buffer_fifo: synchronous FIFO of DEPTH words of WIDTH bits with valid/ready
// handshakes on both sides; word order is preserved.
// Optional feature macro: BUFFER_FIFO_BYPASS_EN -- when defined, a word offered
// to an empty buffer is presented on the output in the same cycle and, if the
// consumer takes it, never enters storage.
module buffer_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);

   // ST_HOLD keeps the input closed for the release cycle after reset
   typedef enum logic {
      ST_HOLD,
      ST_RUN
   } runState_t;

   runState_t         state;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] wrPtr;
   logic [ADDR_W-1:0] rdPtr;
   logic [ADDR_W:0]   count;
   logic              push;
   logic              pop;
   logic              bypassTake;

   assign level    = count;
   assign full     = (count == FULL_LEVEL);
   assign empty    = (count == '0);
   assign in_ready = (state == ST_RUN) && !full;

   // Output presentation and handshake decode
   always_comb begin
      bypassTake = 1'b0;
      out_valid  = !empty;
      out_data   = empty ? '0 : mem[rdPtr];
`ifdef BUFFER_FIFO_BYPASS_EN
      // in_ready is low during reset, so the bypass cannot leak a word then
      if (empty && in_ready && in_valid) begin
         out_valid  = 1'b1;
         out_data   = in_data;
         bypassTake = out_ready;
      end
`endif
      push = in_valid && in_ready && !bypassTake;
      pop  = !empty && out_ready;
   end

   // Open the input one cycle after reset is released
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_HOLD;
      end else begin
         state <= ST_RUN;
      end
   end

   // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            wrPtr <= wrPtr + ADDR_W'(1);
         end
         if (pop) begin
            rdPtr <= rdPtr + ADDR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + (ADDR_W + 1)'(1);
            2'b01:   count <= count - (ADDR_W + 1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage write; contents are deliberately not reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr] <= in_data;
      end
   end

endmodule

// File: tb/tb_buffer_fifo.sv
// tb_buffer_fifo: directed stimulus for buffer_fifo, checked every cycle
// against a queue model plus hand-computed literal expectations.
module tb_buffer_fifo;

   localparam int WIDTH = 16;
   localparam int DEPTH = 4;
`ifdef BUFFER_FIFO_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic [2:0]       level;
   logic             full;
   logic             empty;

   int errors = 0;
   int checks = 0;
   bit cmpEn  = 1'b0;

   logic [WIDTH-1:0] mq [$];
   bit               mRun = 1'b0;

   buffer_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .level(level),
      .full(full),
      .empty(empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Queue model: a word is accepted when running and not full, unless an
   // empty-buffer bypass hands it straight to a ready consumer.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         mRun <= 1'b0;
      end else begin
         if (mRun && in_valid && mq.size() < DEPTH &&
             !(BYP && mq.size() == 0 && out_ready)) begin
            if (mq.size() > 0 && out_ready) void'(mq.pop_front());
            mq.push_back(in_data);
         end else if (mq.size() > 0 && out_ready) begin
            void'(mq.pop_front());
         end
         mRun <= 1'b1;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (cmpEn) begin
         check("cmp_level", 32'(level), 32'(mq.size()));
         check("cmp_full",  32'(full),  32'(mq.size() == DEPTH));
         check("cmp_empty", 32'(empty), 32'(mq.size() == 0));
         check("cmp_in_ready", 32'(in_ready), 32'(mRun && mq.size() < DEPTH));
         if (mq.size() > 0) begin
            check("cmp_out_valid", 32'(out_valid), 32'd1);
            check("cmp_out_data",  32'(out_data),  32'(mq[0]));
         end else if (BYP && mRun && in_valid) begin
            check("cmp_out_valid", 32'(out_valid), 32'd1);
            check("cmp_out_data",  32'(out_data),  32'(in_data));
         end else begin
            check("cmp_out_valid", 32'(out_valid), 32'd0);
            check("cmp_out_data",  32'(out_data),  32'd0);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #1 rst_n = 1'b0;
      #1 cmpEn = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rel_cycle_in_ready", 32'(in_ready), 32'd0);
      step();
      @(negedge clk);
      check("post_rel_in_ready", 32'(in_ready), 32'd1);
      step();

      // Fill to full, drop a fifth word, then drain in order
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 16'hA000 + 16'(i), 1'b0);
         step();
      end
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("fill_full", 32'(full), 32'd1);
      check("fill_level", 32'(level), 32'd4);
      check("fill_in_ready", 32'(in_ready), 32'd0);
      step();
      drive(1'b1, 16'hA005, 1'b0);
      step();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("drop_level", 32'(level), 32'd4);
      step();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("drain_data", 32'(out_data), 32'hA000 + 32'(i));
         step();
      end
      @(negedge clk);
      check("drain_empty", 32'(empty), 32'd1);
      step();
      step();  // pop requested while empty: must be ignored
      @(negedge clk);
      check("underflow_level", 32'(level), 32'd0);

      // Streaming 0..9 with both sides ready
      for (int k = 0; k < 10; k++) begin
         drive(1'b1, 16'(k), 1'b1);
         @(negedge clk);
         if (BYP) begin
            check("stream_byp_data", 32'(out_data), 32'(k));
            check("stream_byp_level", 32'(level), 32'd0);
         end else if (k > 0) begin
            check("stream_data", 32'(out_data), 32'(k - 1));
            check("stream_level", 32'(level), 32'd1);
         end
         step();
      end
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (BYP) check("stream_tail_valid", 32'(out_valid), 32'd0);
      else     check("stream_tail_data", 32'(out_data), 32'd9);
      step();
      @(negedge clk);
      check("stream_end_empty", 32'(empty), 32'd1);
      step();

      // Simultaneous push and pop at level 2
      drive(1'b1, 16'h0011, 1'b0);
      step();
      drive(1'b1, 16'h0022, 1'b0);
      step();
      drive(1'b1, 16'h0033, 1'b1);
      @(negedge clk);
      check("pp_before_data", 32'(out_data), 32'h0011);
      step();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("pp_level", 32'(level), 32'd2);
      check("pp_data", 32'(out_data), 32'h0022);
      out_ready = 1'b1;
      step();
      step();
      out_ready = 1'b0;

      // Reset in the middle of operation
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, 16'hC000 + 16'(i), 1'b0);
         step();
      end
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("mid_level", 32'(level), 32'd3);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_in_ready", 32'(in_ready), 32'd0);
      step();
      rst_n = 1'b1;
      drive(1'b1, 16'hDEAD, 1'b0);
      @(negedge clk);
      check("mid_rel_in_ready", 32'(in_ready), 32'd0);
      step();
      drive(1'b1, 16'hBEEF, 1'b0);
      step();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("beef_data", 32'(out_data), 32'hBEEF);
      check("beef_level", 32'(level), 32'd1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      step();

      // Offer a word to an empty buffer with the consumer ready
      drive(1'b1, 16'h1234, 1'b1);
      @(negedge clk);
      if (BYP) begin
         check("byp_valid", 32'(out_valid), 32'd1);
         check("byp_data", 32'(out_data), 32'h1234);
         check("byp_level", 32'(level), 32'd0);
      end else begin
         check("nobyp_valid", 32'(out_valid), 32'd0);
      end
      step();
      drive(1'b0, '0, 1'b1);
      @(negedge clk);
      if (BYP) begin
         check("byp_after_valid", 32'(out_valid), 32'd0);
         check("byp_after_level", 32'(level), 32'd0);
      end else begin
         check("nobyp_next_valid", 32'(out_valid), 32'd1);
         check("nobyp_next_data", 32'(out_data), 32'h1234);
      end
      step();
      drive(1'b0, '0, 1'b0);
      @(negedge clk);
      check("final_empty", 32'(empty), 32'd1);
      step();

      cmpEn = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
